md_unit_sequencer: RTL and testbench
====================================

# md_unit_sequencer

Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and models the fixed hardware latency with a busy counter. It owns the HI/LO registers and produces the stall request the IF/ID hazard logic ORs into its Install signal, so that any MD-class instruction in ID (including MFHI/MFLO) waits while the unit is busy.

## Interface
- MULT_CYCLES, 5, Busy duration in cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, Busy duration in cycles for DIV/DIVU (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Start  in  1  EX-stage instruction is a valid MD operation this cycle
- MDOp  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- ID_IsMD  in  1  ID-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- Busy  out  1  long operation in progress
- Stall  out  1  ID_IsMD & (Busy | (Start & MDOp in 001..100))
- HI  out  32  HI register
- LO  out  32  LO register

## Operation
- States: IDLE, BUSY. Down-counter cnt, width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- IDLE, Start & MDOp ∈ {MULT, MULTU, DIV, DIVU}: compute the 64-bit result from A/B into result register res; load cnt with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- IDLE, Start & MTHI: HI ← A at the edge. Start & MTLO: LO ← A at the edge. No Busy.
- IDLE, MDOp = 000 or 111: no action.
- BUSY: cnt decrements each cycle. When cnt = 1: HI ← res[63:32], LO ← res[31:0], then go to IDLE.
- Start while BUSY is ignored. It cannot occur because of the Stall output; the bench flags it as an error.
- MULT: signed 32×32→64. MULTU: unsigned.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divisor = 0: the op still occupies BUSY for DIV_CYCLES, and HI/LO keep their prior values (the no-write flag is latched at Start).
- Reset, including mid-operation: state IDLE, cnt 0, Busy 0, HI 0, LO 0, res discarded.

## Timing
- Start accepted in cycle t. Busy = 1 in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO update at the edge ending cycle t+N. New values are visible and Busy = 0 in cycle t+N+1.
- A new Start is accepted in cycle t+N+1. No dead cycle.
- MTHI/MTLO at cycle t: new value visible at t+1.
- Stall is combinational and is valid in cycle t itself, because it covers an MD instruction sitting in ID behind a starting long op. It deasserts in cycle t+N+1.
- MFHI/MFLO read HI/LO directly. The hazard logic guarantees they are never in EX while Busy.
- Outputs HI, LO, and Busy are registered. Stall is the only combinational output.

## Structure
- MDOp encodings and the ID_IsMD decode function funcs (MULT_FUNC, MULTU_FUNC, DIV_FUNC, DIVU_FUNC, MTHI_FUNC, MTLO_FUNC, MFHI_FUNC, MFLO_FUNC) go in the shared defines file next to the existing opcode/funct defines.
- One sub-module, md_arith: purely combinational, inputs (MDOp, A, B), outputs a 64-bit {hi, lo} and a div-by-zero flag.
- The sequencer holds the FSM, the counter, res, and the HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFF, B=0x00000002 → Busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 → Busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTLO A=0x12345678, then DIVU A=7, B=0 → LO stays 0x12345678 and HI stays at its prior value after 10 busy cycles.
- ID_IsMD held at 1 while MULT starts at cycle t → Stall = 1 for cycles t … t+5, and Stall = 0 at t+6 with new HI/LO.
- DIV started, then reset at the 4th busy cycle → next cycle Busy=0, HI=LO=0. A following MULT 3×4 gives LO=12 after 5 cycles.

Source files
------------

// File: rtl/md_unit_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// md_unit_sequencer_pkg
//   Shared definitions for the multiply/divide unit:
//   - MDOp encodings driven by the EX stage into the sequencer
//   - MIPS SPECIAL funct codes for every HI/LO-class instruction
//   - small decode helpers used by the sequencer and by the ID hazard logic
// ---------------------------------------------------------------------------
package md_unit_sequencer_pkg;

  // MDOp encodings (3'b111 is unused and treated as "no action")
  localparam logic [2:0] MDOP_NONE  = 3'b000;
  localparam logic [2:0] MDOP_MULT  = 3'b001;
  localparam logic [2:0] MDOP_MULTU = 3'b010;
  localparam logic [2:0] MDOP_DIV   = 3'b011;
  localparam logic [2:0] MDOP_DIVU  = 3'b100;
  localparam logic [2:0] MDOP_MTHI  = 3'b101;
  localparam logic [2:0] MDOP_MTLO  = 3'b110;

  // SPECIAL-opcode funct field values
  localparam logic [5:0] MFHI_FUNC  = 6'h10;
  localparam logic [5:0] MTHI_FUNC  = 6'h11;
  localparam logic [5:0] MFLO_FUNC  = 6'h12;
  localparam logic [5:0] MTLO_FUNC  = 6'h13;
  localparam logic [5:0] MULT_FUNC  = 6'h18;
  localparam logic [5:0] MULTU_FUNC = 6'h19;
  localparam logic [5:0] DIV_FUNC   = 6'h1A;
  localparam logic [5:0] DIVU_FUNC  = 6'h1B;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for any instruction that reads or writes HI/LO; the ID stage uses
  // this to build ID_IsMD for a SPECIAL-opcode instruction.
  function automatic logic id_is_md(input logic [5:0] funct);
    case (funct)
      MFHI_FUNC, MTHI_FUNC, MFLO_FUNC, MTLO_FUNC,
      MULT_FUNC, MULTU_FUNC, DIV_FUNC, DIVU_FUNC: id_is_md = 1'b1;
      default:                                     id_is_md = 1'b0;
    endcase
  endfunction

  // Operations that occupy the unit for several cycles
  function automatic logic is_long_op(input logic [2:0] op);
    is_long_op = (op == MDOP_MULT) || (op == MDOP_MULTU) ||
                 (op == MDOP_DIV)  || (op == MDOP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    is_div_op = (op == MDOP_DIV) || (op == MDOP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_sequencer_arith.sv
// ---------------------------------------------------------------------------
// md_arith
//   Purely combinational multiply/divide datapath.
//   Ports:
//     MDOp      in  3   operation select (only MULT/MULTU/DIV/DIVU produce data)
//     A, B      in  32  rs / rt operands
//     result    out 64  {hi, lo}: product, or {remainder, quotient}
//     div_zero  out 1   divide op with B == 0 (result must not be written)
// ---------------------------------------------------------------------------
module md_arith
  import md_unit_sequencer_pkg::*;
(
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic        [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag;
  logic        [31:0] b_mag;
  logic        [31:0] num;
  logic        [31:0] den;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] quot;
  logic        [31:0] rem;
  logic               signed_div;

  always_comb begin
    a_sext = {{32{A[31]}}, A};
    b_sext = {{32{B[31]}}, B};
    prod_s = a_sext * b_sext;
    prod_u = {32'd0, A} * {32'd0, B};

    // Signed division goes through magnitudes so truncation toward zero and
    // the dividend-signed remainder fall out naturally. The magnitude of
    // 0x80000000 is 0x80000000 as an unsigned value, so the overflow case
    // 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
    signed_div = (MDOp == MDOP_DIV);
    a_mag      = A[31] ? (~A + 32'd1) : A;
    b_mag      = B[31] ? (~B + 32'd1) : B;
    num        = signed_div ? a_mag : A;
    // A zero divisor is replaced with 1 only to keep the divider defined;
    // the result is discarded via div_zero.
    den        = (B == 32'd0) ? 32'd1 : (signed_div ? b_mag : B);
    q_mag      = num / den;
    r_mag      = num % den;

    quot = q_mag;
    rem  = r_mag;
    if (signed_div) begin
      if (A[31] ^ B[31]) quot = ~q_mag + 32'd1;
      if (A[31])         rem  = ~r_mag + 32'd1;
    end

    case (MDOp)
      MDOP_MULT:            result = prod_s;
      MDOP_MULTU:           result = prod_u;
      MDOP_DIV, MDOP_DIVU:  result = {rem, quot};
      default:              result = 64'd0;
    endcase

    div_zero = is_div_op(MDOp) && (B == 32'd0);
  end

endmodule

// File: rtl/md_unit_sequencer.sv
// ---------------------------------------------------------------------------
// md_unit_sequencer
//   Multi-cycle multiply/divide sequencer. Owns HI/LO, models the fixed
//   hardware latency with a down-counter and raises the ID-stage stall.
//   Parameters:
//     MULT_CYCLES  busy cycles for MULT/MULTU
//     DIV_CYCLES   busy cycles for DIV/DIVU
//   Ports:
//     clk, reset   rising-edge clock, synchronous active-high reset
//     Start        EX-stage MD operation valid this cycle
//     MDOp         operation encoding (see package)
//     A, B         forwarded rs / rt operands
//     ID_IsMD      ID-stage instruction touches HI/LO
//     Busy         registered: long operation in progress
//     Stall        combinational hazard request to IF/ID
//     HI, LO       registered HI/LO
// ---------------------------------------------------------------------------
module md_unit_sequencer
  import md_unit_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ID_IsMD,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [63:0]      res_reg;
  logic             no_write_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;

  logic [63:0]      arith_result;
  logic             arith_div_zero;

  md_arith u_arith (
    .MDOp     (MDOp),
    .A        (A),
    .B        (B),
    .result   (arith_result),
    .div_zero (arith_div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= MD_IDLE;
      cnt_reg      <= '0;
      res_reg      <= 64'd0;
      no_write_reg <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (Start) begin
            if (is_long_op(MDOp)) begin
              // Result is captured now so A/B need not be held while busy.
              res_reg      <= arith_result;
              no_write_reg <= arith_div_zero;
              cnt_reg      <= is_div_op(MDOp) ? DIV_LOAD : MULT_LOAD;
              state_reg    <= MD_BUSY;
            end else if (MDOp == MDOP_MTHI) begin
              hi_reg <= A;
            end else if (MDOp == MDOP_MTLO) begin
              lo_reg <= A;
            end
          end
        end
        MD_BUSY: begin
          // Start is ignored here; the Stall output keeps it from happening.
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            if (!no_write_reg) begin
              hi_reg <= res_reg[63:32];
              lo_reg <= res_reg[31:0];
            end
            state_reg <= MD_IDLE;
          end
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

  assign Busy = (state_reg == MD_BUSY);
  assign HI   = hi_reg;
  assign LO   = lo_reg;

  // Covers an MD instruction in ID sitting directly behind a long op that
  // is starting in EX this very cycle, before Busy has had a chance to rise.
  assign Stall = ID_IsMD & (Busy | (Start & is_long_op(MDOp)));

endmodule

// File: tb/tb_md_unit_sequencer.sv
module tb_md_unit_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        ID_IsMD;
  logic        Busy;
  logic        Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  md_unit_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDOp    (MDOp),
    .A       (A),
    .B       (B),
    .ID_IsMD (ID_IsMD),
    .Busy    (Busy),
    .Stall   (Stall),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          checking = 0;
  int          rem_cycles = 0;   // model: busy cycles still to come
  bit          cmp_pending = 0;  // model: HI/LO result lands at this edge
  logic [31:0] model_hi = 0;
  logic [31:0] model_lo = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: results straight from the arithmetic definitions.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] ch,
                                         input logic [31:0] cl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    res = {ch, cl};
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      3'd4: if (b != 0) begin uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]}; end
      3'd5: res = {a, cl};
      3'd6: res = {ch, a};
      default: res = {ch, cl};
    endcase
    return res;
  endfunction

  // Timing model: when each operation completes and how long Busy lasts.
  always @(posedge clk) begin
    if (reset) begin
      rem_cycles  = 0;
      cmp_pending = 0;
    end else begin
      cmp_pending = (rem_cycles == 1) ||
                    (rem_cycles == 0 && Start && (MDOp == 3'd5 || MDOp == 3'd6));
      if (rem_cycles > 0) begin
        if (Start && checking) begin
          n_cmp++;
          n_bad++;
          $display("FAIL start_while_busy: got Start=1, want 0 at %0t", $time);
        end
        rem_cycles--;
      end else if (Start && MDOp >= 3'd1 && MDOp <= 3'd4) begin
        rem_cycles = (MDOp >= 3'd3) ? DIV_N : MULT_N;
      end
    end
  end

  // Monitor: per-cycle Busy/Stall, and scoreboard pop when a result lands.
  always @(negedge clk) begin
    if (checking) begin
      logic exp_stall;
      exp_t e;
      exp_stall = ID_IsMD && ((rem_cycles > 0) || (Start && MDOp >= 3'd1 && MDOp <= 3'd4));
      check("busy", 32'(Busy), 32'(rem_cycles > 0));
      check("stall", 32'(Stall), 32'(exp_stall));
      if (cmp_pending) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hi"}, HI, e.hi);
          check({e.name, "_lo"}, LO, e.lo);
        end
      end
    end
  end

  function automatic string op_name(input logic [2:0] op);
    case (op)
      3'd1: return "mult";
      3'd2: return "multu";
      3'd3: return "div";
      3'd4: return "divu";
      3'd5: return "mthi";
      3'd6: return "mtlo";
      default: return "nop";
    endcase
  endfunction

  // Drive one operation for one cycle and push its expected HI/LO.
  // Called and returns at posedge+1.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic idmd);
    logic [63:0] r;
    exp_t        e;
    Start = 1; MDOp = op; A = a; B = b; ID_IsMD = idmd;
    if (op >= 3'd1 && op <= 3'd6) begin
      r = ref_op(op, a, b, model_hi, model_lo);
      model_hi = r[63:32];
      model_lo = r[31:0];
      e.hi = r[63:32]; e.lo = r[31:0]; e.name = op_name(op);
      sb_q.push_back(e);
      $display("issue %-5s A=%h B=%h -> HI=%h LO=%h", e.name, a, b, e.hi, e.lo);
    end else begin
      $display("issue nop   MDOp=%0d A=%h B=%h", op, a, b);
    end
    @(posedge clk); #1;
    Start = 0; MDOp = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic idmd, input bit hold);
    int n;
    drive_op(op, a, b, idmd);
    n = 0;
    while (rem_cycles != 0 && n < 40) begin
      ID_IsMD = hold ? 1'b1 : 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (rem_cycles != 0) check("busy_timeout", 32'(rem_cycles), 32'd0);
    ID_IsMD = hold ? 1'b1 : 1'($urandom);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;
    reset = 1; Start = 0; MDOp = 0; A = 0; B = 0; ID_IsMD = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    checking = 1;

    // Directed cases
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1);
    // Hold ID_IsMD for one idle cycle: Stall must be low again at t+6.
    @(posedge clk); #1;
    issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0);
    issue(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
    issue(3'd6, 32'h1234_5678, 32'h0,         1'b1, 1'b0);
    issue(3'd4, 32'h0000_0007, 32'h0,         1'b1, 1'b0);
    issue(3'd5, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(3'd3, 32'h0000_0064, 32'h0,         1'b0, 1'b0);
    issue(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
    issue(3'd7, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);

    // Reset in the 4th busy cycle of a DIV
    drive_op(3'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1;
    sb_q.delete();
    model_hi = 0;
    model_lo = 0;
    $display("reset during div");
    @(posedge clk); #1;
    reset = 0;
    check("midreset_busy", 32'(Busy), 32'd0);
    check("midreset_hi", HI, 32'd0);
    check("midreset_lo", LO, 32'd0);
    issue(3'd1, 32'd3, 32'd4, 1'b1, 1'b0);

    // Randomized operations, back-to-back or with short gaps
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      else if (sel == 3) begin a = -($urandom_range(0, 50)); b = -($urandom_range(1, 9)); end
      issue(op, a, b, 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        ID_IsMD = 1'($urandom);
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
